// File: rtl/tb_wait_event_if.sv
// Command/status bundle between the scenario decoder/sequencer and the
// wait-event execution stage. The master drives the command and the monitored
// signals. The slave (tb_wait_event) returns busy, ack and status.
interface tb_wait_event_if #(
    parameter int N_SIG = 32,
    parameter int IDX_W = 5,
    parameter int TMO_W = 32
);
    logic             i_sel_wait;
    logic             i_start;
    logic             i_edge_fall;
    logic [IDX_W-1:0] i_sig_idx;
    logic [TMO_W-1:0] i_timeout;
    logic [N_SIG-1:0] i_wait_signals;
    logic             o_busy;
    logic             o_ack;
    logic             o_timeout;
    logic             o_err;
    logic [TMO_W-1:0] o_elapsed;

    modport master (
        output i_sel_wait, i_start, i_edge_fall, i_sig_idx, i_timeout, i_wait_signals,
        input  o_busy, o_ack, o_timeout, o_err, o_elapsed
    );

    modport slave (
        input  i_sel_wait, i_start, i_edge_fall, i_sig_idx, i_timeout, i_wait_signals,
        output o_busy, o_ack, o_timeout, o_err, o_elapsed
    );
endinterface

// File: rtl/tb_wait_event.sv
// Wait-event execution stage. It waits for a rising (WTR) or falling (WTF) edge
// on one selected monitored signal, or for a cycle timeout. It then returns a
// one-cycle ack with status, so the scenario sequencer can advance.
module tb_wait_event #(
    parameter int N_SIG = 32,
    parameter int IDX_W = 5,
    parameter int TMO_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    tb_wait_event_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state;
    logic             edge_fall_q;
    logic [IDX_W-1:0] idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic             prev_q;
    logic [TMO_W-1:0] elapsed_q;
    logic             ack_q;
    logic             timeout_q;
    logic             err_q;

    logic             cur;
    logic             start_bit;
    logic             hit;
    logic             idx_oor;
    logic [TMO_W-1:0] k_next;

    // Mux one monitored bit by index. Out-of-range indices read as 0.
    function automatic logic pick(input logic [N_SIG-1:0] sigs, input logic [IDX_W-1:0] idx);
        logic r;
        // NOTE: give r a value before the loop. A variable that only some paths assign infers a latch.
        r = 1'b0;
        for (int i = 0; i < N_SIG; i++) begin
            if (idx == IDX_W'(i)) r = sigs[i];
        end
        return r;
    endfunction

    // Edge detection on the latched index, the saturating elapsed count, and the range check.
    always_comb begin
        cur       = pick(bus.i_wait_signals, idx_q);
        start_bit = pick(bus.i_wait_signals, bus.i_sig_idx);
        hit       = edge_fall_q ? (prev_q & ~cur) : (~prev_q & cur);
        k_next    = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
        idx_oor   = 32'(bus.i_sig_idx) >= N_SIG;
    end

    // Command FSM: accept in IDLE, monitor in WAIT, and finish with a single registered ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            edge_fall_q <= 1'b0;
            idx_q       <= '0;
            tmo_q       <= '0;
            prev_q      <= 1'b0;
            elapsed_q   <= '0;
            ack_q       <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments only. The ack default below is overridden later in the same block, and every read sees the pre-edge value.
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start && bus.i_sel_wait) begin
                        edge_fall_q <= bus.i_edge_fall;
                        idx_q       <= bus.i_sig_idx;
                        tmo_q       <= bus.i_timeout;
                        prev_q      <= start_bit;
                        elapsed_q   <= '0;
                        timeout_q   <= 1'b0;
                        if (idx_oor) begin
                            ack_q <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    elapsed_q <= k_next;
                    if (hit) begin
                        ack_q     <= 1'b1;
                        timeout_q <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (tmo_q != '0 && k_next == tmo_q) begin
                        ack_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        prev_q <= cur;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy    = (state == ST_WAIT);
    assign bus.o_ack     = ack_q;
    assign bus.o_timeout = timeout_q;
    assign bus.o_err     = err_q;
    assign bus.o_elapsed = elapsed_q;

endmodule

// File: tb/tb_tb_wait_event.sv
// Directed bench for tb_wait_event. Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_tb_wait_event;

    localparam int N_SIG = 20;
    localparam int IDX_W = 5;
    localparam int TMO_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt;

    tb_wait_event_if #(.N_SIG(N_SIG), .IDX_W(IDX_W), .TMO_W(TMO_W)) bus ();

    tb_wait_event #(.N_SIG(N_SIG), .IDX_W(IDX_W), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one edge.
    task automatic issue(input logic sel, input logic fall, input logic [IDX_W-1:0] idx,
                         input logic [TMO_W-1:0] tmo);
        bus.i_start     = 1'b1;
        bus.i_sel_wait  = sel;
        bus.i_edge_fall = fall;
        bus.i_sig_idx   = idx;
        bus.i_timeout   = tmo;
        tick();
        bus.i_start     = 1'b0;
        bus.i_sel_wait  = 1'b0;
    endtask

    // Run n edges and count how many acks appear.
    task automatic run_count(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.o_ack) acks++;
        end
    endtask

    initial begin
        bus.i_sel_wait     = 1'b0;
        bus.i_start        = 1'b0;
        bus.i_edge_fall    = 1'b0;
        bus.i_sig_idx      = '0;
        bus.i_timeout      = '0;
        bus.i_wait_signals = '0;
        tick();
        tick();
        check("rst_busy", bus.o_busy, 0);
        check("rst_ack", bus.o_ack, 0);
        check("rst_err", bus.o_err, 0);
        check("rst_tmo", bus.o_timeout, 0);
        check("rst_elapsed", bus.o_elapsed, 0);
        rst = 1'b0;
        tick();

        // WTR idx3 tmo10: the bit rises at WAIT edge 4.
        issue(1'b1, 1'b0, 5'd3, 10);
        check("wtr_busy_after_accept", bus.o_busy, 1);
        check("wtr_elapsed_at_accept", bus.o_elapsed, 0);
        run_count(3, ack_cnt);
        check("wtr_no_early_ack", ack_cnt, 0);
        check("wtr_elapsed_k3", bus.o_elapsed, 3);
        bus.i_wait_signals[3] = 1'b1;
        tick();
        check("wtr_ack", bus.o_ack, 1);
        check("wtr_tmo", bus.o_timeout, 0);
        check("wtr_elapsed", bus.o_elapsed, 4);
        check("wtr_busy_in_ack", bus.o_busy, 0);
        tick();
        check("wtr_ack_single", bus.o_ack, 0);

        // WTF idx0 with no timeout: the bit falls at WAIT edge 100.
        bus.i_wait_signals[0] = 1'b1;
        issue(1'b1, 1'b1, 5'd0, 0);
        run_count(99, ack_cnt);
        check("wtf_no_early_ack", ack_cnt, 0);
        bus.i_wait_signals[0] = 1'b0;
        tick();
        check("wtf_ack", bus.o_ack, 1);
        check("wtf_tmo", bus.o_timeout, 0);
        check("wtf_elapsed", bus.o_elapsed, 100);

        // WTR idx7 tmo5: the bit stays low, so the wait times out at edge 5.
        tick();
        issue(1'b1, 1'b0, 5'd7, 5);
        run_count(4, ack_cnt);
        check("tmo_no_early_ack", ack_cnt, 0);
        tick();
        check("tmo_ack", bus.o_ack, 1);
        check("tmo_flag", bus.o_timeout, 1);
        check("tmo_elapsed", bus.o_elapsed, 5);

        // Same command, but the bit rises at exactly edge 5, so the edge wins over the timeout.
        tick();
        issue(1'b1, 1'b0, 5'd7, 5);
        run_count(4, ack_cnt);
        bus.i_wait_signals[7] = 1'b1;
        tick();
        check("tie_ack", bus.o_ack, 1);
        check("tie_tmo", bus.o_timeout, 0);
        check("tie_elapsed", bus.o_elapsed, 5);
        bus.i_wait_signals[7] = 1'b0;

        // Index 25 is out of range for 20 signals.
        tick();
        issue(1'b1, 1'b0, 5'd25, 3);
        check("oor_ack", bus.o_ack, 1);
        check("oor_err", bus.o_err, 1);
        check("oor_busy", bus.o_busy, 0);
        check("oor_tmo", bus.o_timeout, 0);
        check("oor_elapsed", bus.o_elapsed, 0);
        tick();
        check("oor_ack_single", bus.o_ack, 0);
        check("oor_busy_later", bus.o_busy, 0);

        // Reset at WAIT edge 3 aborts the wait without an ack.
        bus.i_wait_signals = '0;
        issue(1'b1, 1'b0, 5'd3, 0);
        check("abort_err_cleared", bus.o_err, 0);
        run_count(2, ack_cnt);
        rst = 1'b1;
        tick();
        check("abort_busy", bus.o_busy, 0);
        check("abort_ack", bus.o_ack, 0);
        check("abort_elapsed", bus.o_elapsed, 0);
        rst = 1'b0;
        bus.i_wait_signals[3] = 1'b1;
        run_count(4, ack_cnt);
        check("abort_no_ack", ack_cnt, 0);
        check("abort_idle", bus.o_busy, 0);

        // A second start during WAIT is ignored.
        bus.i_wait_signals = '0;
        issue(1'b1, 1'b0, 5'd3, 10);
        issue(1'b1, 1'b1, 5'd7, 2);
        run_count(2, ack_cnt);
        check("restart_ignored_no_ack", ack_cnt, 0);
        bus.i_wait_signals[3] = 1'b1;
        tick();
        check("restart_ignored_ack", bus.o_ack, 1);
        check("restart_ignored_elapsed", bus.o_elapsed, 4);

        // A start with i_sel_wait=0 is not a wait command.
        tick();
        issue(1'b0, 1'b0, 5'd3, 10);
        check("nosel_busy", bus.o_busy, 0);
        run_count(3, ack_cnt);
        check("nosel_no_ack", ack_cnt, 0);

        // Back-to-back: a new WTR is issued in the ack cycle of the previous one.
        bus.i_wait_signals = '0;
        issue(1'b1, 1'b0, 5'd3, 10);
        tick();
        bus.i_wait_signals[3] = 1'b1;
        tick();
        check("b2b_first_ack", bus.o_ack, 1);
        check("b2b_first_elapsed", bus.o_elapsed, 2);
        issue(1'b1, 1'b0, 5'd7, 3);
        check("b2b_accept_busy", bus.o_busy, 1);
        check("b2b_accept_elapsed", bus.o_elapsed, 0);
        check("b2b_accept_ack_low", bus.o_ack, 0);
        tick();
        bus.i_wait_signals[7] = 1'b1;
        tick();
        check("b2b_second_ack", bus.o_ack, 1);
        check("b2b_second_tmo", bus.o_timeout, 0);
        check("b2b_second_elapsed", bus.o_elapsed, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tb_wait_event.md
Name: tb_wait_event

Overview:
- Execution stage directly downstream of the scenario command decoder in the testbench.
- Consumes the decoder's wait selection (WTR/WTF commands) plus decoded arguments: signal index, edge type and timeout.
- Waits for a rising or falling edge on one selected signal of a monitored bus, or for a cycle timeout.
- Returns a one-cycle acknowledge with status, so the scenario sequencer can advance to the next command.

Parameters:
- N_SIG, 32, number of monitored wait signals.
- IDX_W, 5, width of signal index; must satisfy 2**IDX_W >= N_SIG.
- TMO_W, 32, width of timeout and elapsed-cycle counters.

Ports:
- clk  in  1  testbench clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- i_sel_wait  in  1  decoder wait selection (WTR or WTF command present).
- i_start  in  1  command-valid strobe; start accepted only when i_sel_wait=1.
- i_edge_fall  in  1  0 = wait rising edge (WTR), 1 = wait falling edge (WTF).
- i_sig_idx  in  IDX_W  index into i_wait_signals.
- i_timeout  in  TMO_W  timeout in WAIT cycles; 0 = no timeout.
- i_wait_signals  in  N_SIG  monitored signals, synchronous to clk.
- o_busy  out  1  high while state = WAIT.
- o_ack  out  1  one-cycle completion pulse.
- o_timeout  out  1  status, valid with o_ack: wait ended by timeout.
- o_err  out  1  status, valid with o_ack: index out of range.
- o_elapsed  out  TMO_W  WAIT cycles consumed by last command; held until next accept.

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE; o_busy, o_ack, o_timeout, o_err = 0; o_elapsed = 0; internal config/prev registers = 0. Takes priority over everything. Reset mid-WAIT aborts with no ack.
- FSM states:
  - IDLE: waiting for a command.
  - WAIT: monitoring the selected signal.
- No other states. o_ack, o_timeout and o_err are registered.
- Accept: at an edge where state=IDLE, i_start=1 and i_sel_wait=1:
  - latch i_edge_fall, i_sig_idx, i_timeout;
  - prev <= i_wait_signals[i_sig_idx];
  - o_elapsed <= 0; o_timeout <= 0; o_err <= 0.
- i_start with i_sel_wait=0 is ignored. i_start in WAIT is ignored; no queuing.
- Out-of-range index (i_sig_idx >= N_SIG) at accept:
  - stay IDLE; o_ack=1 and o_err=1 for the next cycle;
  - o_timeout=0, o_elapsed=0.
- WAIT edge k (k = 1, 2, ... after accept), cur = i_wait_signals[idx]:
  - Detection: rising = (prev=0 and cur=1); falling = (prev=1 and cur=0); the active type is selected by the latched edge flag.
  - On detection: o_elapsed <= k; o_ack <= 1; o_timeout <= 0; state <= IDLE.
  - Otherwise, if timeout != 0 and k == timeout: o_elapsed <= k; o_ack <= 1; o_timeout <= 1; state <= IDLE.
  - Otherwise: o_elapsed <= k, saturating at all-ones when timeout=0; prev <= cur.
- Simultaneous edge and timeout at the same k: the edge wins (o_timeout=0).
- Latency:
  - o_busy rises the cycle after accept.
  - o_ack is high in the cycle immediately after the detection or timeout edge; o_busy falls in that same cycle.
- A new command may be accepted in the cycle where o_ack=1, since state is already IDLE.
- o_ack is never high for two consecutive cycles from a single command.
- Glitches that start and end between samples are not seen; only sampled values count.
- Signal already at target level at accept: no edge. An opposite-then-target transition is still required.

Test Plan:
- WTR idx=3, timeout=10; bit3 low at accept, rises at WAIT edge 4 -> o_ack=1 one cycle, o_timeout=0, o_elapsed=4, o_busy low in ack cycle.
- WTF idx=0, timeout=0; bit0 high, falls at WAIT edge 100 -> ack with o_elapsed=100, o_timeout=0.
- WTR idx=7, timeout=5; bit7 held low -> ack at WAIT edge 5 with o_timeout=1, o_elapsed=5. Repeat with rise at exactly edge 5 -> o_timeout=0.
- N_SIG=20, idx=25 -> ack next cycle with o_err=1, o_busy never asserted.
- Assert rst at WAIT edge 3 -> all outputs 0, no ack. Second i_start during WAIT ignored. Start with i_sel_wait=0 -> no busy.
- Back-to-back: new WTR issued in ack cycle -> accepted; second ack correct, o_elapsed reset to 0 at second accept.
